// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: function codes, default width, result record
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9
    } alu_func_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  overflow;
        logic                  exception;
    } alu_result_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// rtl/alu_result_queue_if.sv - ALU result queue bus; event counters present only with ALU_EVENT_CNT_EN
interface alu_result_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
`ifdef ALU_EVENT_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_result;
    logic                    in_zero;
    logic                    in_overflow;
    logic                    in_exception;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_result;
    logic                    out_zero;
    logic                    out_overflow;
    logic                    out_exception;
    logic [$clog2(DEPTH):0]  level;
    logic                    sticky_ovf;
    logic                    sticky_exc;
    logic                    sticky_clr;
`ifdef ALU_EVENT_CNT_EN
    logic [CNT_WIDTH-1:0]    ovf_cnt;
    logic [CNT_WIDTH-1:0]    exc_cnt;
`endif

    modport slave (
        input  in_valid, in_result, in_zero, in_overflow, in_exception,
        input  out_ready, sticky_clr,
        output in_ready, out_valid, out_result, out_zero, out_overflow, out_exception,
        output level, sticky_ovf, sticky_exc
`ifdef ALU_EVENT_CNT_EN
        ,
        output ovf_cnt, exc_cnt
`endif
    );

    modport master (
        output in_valid, in_result, in_zero, in_overflow, in_exception,
        output out_ready, sticky_clr,
        input  in_ready, out_valid, out_result, out_zero, out_overflow, out_exception,
        input  level, sticky_ovf, sticky_exc
`ifdef ALU_EVENT_CNT_EN
        ,
        input  ovf_cnt, exc_cnt
`endif
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter; a clear coinciding with an increment yields 1
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - show-ahead ALU result FIFO with sticky status; ALU_EVENT_CNT_EN adds event counters
module alu_result_queue #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4
`ifdef ALU_EVENT_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_queue_if.slave q
);
    import alu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    alu_result_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_exc_q, sticky_exc_d;
    logic             can_push, has_data, push, pop;
    alu_result_t      head, wr_entry;

    // Handshake readiness depends only on registered occupancy.
    assign can_push = (level_q != FULL_LVL);
    assign has_data = (level_q != '0);
    assign push     = q.in_valid && can_push;
    assign pop      = q.out_ready && has_data;

    assign wr_entry.result    = q.in_result;
    assign wr_entry.zero      = q.in_zero;
    assign wr_entry.overflow  = q.in_overflow;
    assign wr_entry.exception = q.in_exception;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        // Setting takes priority over a simultaneous clear.
        sticky_ovf_d = (sticky_ovf_q && !q.sticky_clr) || (push && q.in_overflow);
        sticky_exc_d = (sticky_exc_q && !q.sticky_clr) || (push && q.in_exception);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            sticky_ovf_q <= 1'b0;
            sticky_exc_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_exc_q <= sticky_exc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign q.in_ready      = can_push;
    assign q.out_valid     = has_data;
    assign q.out_result    = has_data ? head.result    : '0;
    assign q.out_zero      = has_data ? head.zero      : 1'b0;
    assign q.out_overflow  = has_data ? head.overflow  : 1'b0;
    assign q.out_exception = has_data ? head.exception : 1'b0;
    assign q.level         = level_q;
    assign q.sticky_ovf    = sticky_ovf_q;
    assign q.sticky_exc    = sticky_exc_q;

`ifdef ALU_EVENT_CNT_EN
    sat_counter #(.WIDTH(CNT_WIDTH)) u_ovf_cnt (
        .clk (clk),
        .rst (rst),
        .clr (q.sticky_clr),
        .inc (push && q.in_overflow),
        .cnt (q.ovf_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_exc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (q.sticky_clr),
        .inc (push && q.in_exception),
        .cnt (q.exc_cnt)
    );
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - randomized self-checking bench for alu_result_queue against a queue model
module tb_alu_result_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
`ifdef ALU_EVENT_CNT_EN
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    alu_result_t mq[$];
    bit m_sovf, m_sexc;
    int m_ocnt, m_ecnt;

`ifdef ALU_EVENT_CNT_EN
    alu_result_queue_if #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) bus ();
    alu_result_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .rst(rst), .q(bus));
`else
    alu_result_queue_if #(.DATA_WIDTH(32), .DEPTH(DEPTH)) bus ();
    alu_result_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .q(bus));
`endif

    task automatic drive(input bit iv, input logic [31:0] r, input bit z, input bit o,
                         input bit e, input bit ordy, input bit clr);
        bus.in_valid     = iv;
        bus.in_result    = r;
        bus.in_zero      = z;
        bus.in_overflow  = o;
        bus.in_exception = e;
        bus.out_ready    = ordy;
        bus.sticky_clr   = clr;
    endtask

    // Model update from the current inputs, then advance one clock.
    task automatic step();
        bit push, pop;
        push = bus.in_valid && (mq.size() < DEPTH);
        pop  = bus.out_ready && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            m_sovf = 0; m_sexc = 0; m_ocnt = 0; m_ecnt = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{result: bus.in_result, zero: bus.in_zero,
                                     overflow: bus.in_overflow, exception: bus.in_exception});
            m_sovf = (m_sovf && !bus.sticky_clr) || (push && bus.in_overflow);
            m_sexc = (m_sexc && !bus.sticky_clr) || (push && bus.in_exception);
`ifdef ALU_EVENT_CNT_EN
            if (bus.sticky_clr) m_ocnt = (push && bus.in_overflow) ? 1 : 0;
            else if (push && bus.in_overflow && m_ocnt < CMAX) m_ocnt++;
            if (bus.sticky_clr) m_ecnt = (push && bus.in_exception) ? 1 : 0;
            else if (push && bus.in_exception && m_ecnt < CMAX) m_ecnt++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [41:0] exp_vec();
        alu_result_t h;
        h = '0;
        if (mq.size() > 0) h = mq[0];
        return {mq.size() < DEPTH, mq.size() > 0, 3'(mq.size()), h, m_sovf, m_sexc};
    endfunction

    function automatic logic [41:0] obs_vec();
        return {bus.in_ready, bus.out_valid, bus.level, bus.out_result, bus.out_zero,
                bus.out_overflow, bus.out_exception, bus.sticky_ovf, bus.sticky_exc};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.level !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.level); else passed++;
        total++; if (bus.out_result !== 32'h0) $display("FAIL reset_out_result: got %h want 0", bus.out_result); else passed++;
        total++; if ({bus.sticky_ovf, bus.sticky_exc} !== 2'b00)
            $display("FAIL reset_sticky: got %b want 00", {bus.sticky_ovf, bus.sticky_exc}); else passed++;
        step();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_fill_drain();
        logic [31:0] vals [4];
        bit          zf   [4];
        vals = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        zf   = '{0, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive(1, vals[i], zf[i], 0, 0, 0, 0);
            step();
            total++; if (bus.level !== 3'(i + 1)) $display("FAIL fill_level%0d: got %0d want %0d", i, bus.level, i + 1); else passed++;
        end
        total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus.in_ready); else passed++;
        drive(1, 32'h1234, 0, 0, 0, 0, 0);
        step();
        total++; if (bus.level !== 3'd4) $display("FAIL full_push_ignored: level got %0d want 4", bus.level); else passed++;
        for (int i = 0; i < 4; i++) begin
            drive(0, 32'h0, 0, 0, 0, 1, 0);
            total++; if (bus.out_result !== vals[i]) $display("FAIL drain_result%0d: got %h want %h", i, bus.out_result, vals[i]); else passed++;
            total++; if (bus.out_zero !== zf[i]) $display("FAIL drain_zero%0d: got %b want %b", i, bus.out_zero, zf[i]); else passed++;
            step();
        end
        total++; if ({bus.out_valid, bus.out_result} !== 33'h0)
            $display("FAIL drained_outputs: got valid=%b result=%h want 0/0", bus.out_valid, bus.out_result); else passed++;
        step();
        total++; if (bus.level !== 3'd0) $display("FAIL empty_pop_ignored: level got %0d want 0", bus.level); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1, $urandom, 1'($urandom), 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 14; i++) begin
            drive(1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
            total++; if (bus.level !== 3'd2) $display("FAIL stream_level%0d: got %0d want 2", i, bus.level); else passed++;
            total++; if (obs_vec() !== exp_vec()) $display("FAIL stream_head%0d: got %h want %h", i, obs_vec(), exp_vec()); else passed++;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 0, 0, 0, 1, 0);
            total++; if (obs_vec() !== exp_vec()) $display("FAIL stream_tail%0d: got %h want %h", i, obs_vec(), exp_vec()); else passed++;
            step();
        end
    endtask

    task automatic test_sticky();
        drive(0, 32'h0, 0, 0, 0, 1, 1);
        step();
        total++; if (bus.sticky_ovf !== 1'b0) $display("FAIL sticky_clr_only: got %b want 0", bus.sticky_ovf); else passed++;
        drive(1, $urandom, 0, 1, 0, 1, 1);
        step();
        total++; if (bus.sticky_ovf !== 1'b1) $display("FAIL sticky_set_wins: got %b want 1", bus.sticky_ovf); else passed++;
        total++; if (bus.sticky_exc !== 1'b0) $display("FAIL sticky_exc_quiet: got %b want 0", bus.sticky_exc); else passed++;
        total++; if (bus.out_overflow !== 1'b1) $display("FAIL flag_stored: got %b want 1", bus.out_overflow); else passed++;
        drive(1, $urandom, 0, 0, 1, 1, 0);
        step();
        total++; if (bus.sticky_exc !== 1'b1) $display("FAIL sticky_exc_set: got %b want 1", bus.sticky_exc); else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 1);
        step();
        total++; if ({bus.sticky_ovf, bus.sticky_exc} !== 2'b00)
            $display("FAIL sticky_cleared: got %b want 00", {bus.sticky_ovf, bus.sticky_exc}); else passed++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, 0, 0, 0, 0, 0);
            step();
        end
        total++; if (bus.level !== 3'd3) $display("FAIL prereset_level: got %0d want 3", bus.level); else passed++;
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        total++; if ({bus.level, bus.out_valid} !== 4'b0000)
            $display("FAIL midreset_state: got level=%0d valid=%b want 0/0", bus.level, bus.out_valid); else passed++;
        v = $urandom;
        drive(1, v, 0, 0, 0, 0, 0);
        step();
        total++; if ({bus.out_valid, bus.out_result} !== {1'b1, v})
            $display("FAIL postreset_head: got valid=%b result=%h want 1/%h", bus.out_valid, bus.out_result, v); else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 0);
        step();
    endtask

    task automatic test_random();
        int pv, pr;
        for (int i = 0; i < 400; i++) begin
            pv = (i < 200) ? 80 : 30;
            pr = (i < 200) ? 30 : 80;
            drive($urandom_range(99) < pv, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(99) < pr, $urandom_range(99) < 5);
            total++; if (obs_vec() !== exp_vec()) $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec()); else passed++;
`ifdef ALU_EVENT_CNT_EN
            total++; if ({bus.ovf_cnt, bus.exc_cnt} !== {2'(m_ocnt), 2'(m_ecnt)})
                $display("FAIL random_cnt%0d: got %0d/%0d want %0d/%0d", i, bus.ovf_cnt, bus.exc_cnt, m_ocnt, m_ecnt); else passed++;
`endif
            step();
        end
    endtask

`ifdef ALU_EVENT_CNT_EN
    task automatic test_counters();
        drive(0, 32'h0, 0, 0, 0, 1, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, $urandom, 0, 0, 1, 1, 0);
            step();
        end
        total++; if (bus.exc_cnt !== 2'd3) $display("FAIL exc_cnt_sat: got %0d want 3", bus.exc_cnt); else passed++;
        total++; if (bus.ovf_cnt !== 2'd0) $display("FAIL ovf_cnt_idle: got %0d want 0", bus.ovf_cnt); else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 1);
        step();
        total++; if (bus.exc_cnt !== 2'd0) $display("FAIL exc_cnt_clr: got %0d want 0", bus.exc_cnt); else passed++;
        drive(1, $urandom, 0, 1, 0, 1, 1);
        step();
        total++; if (bus.ovf_cnt !== 2'd1) $display("FAIL ovf_cnt_clr_inc: got %0d want 1", bus.ovf_cnt); else passed++;
        drive(0, 32'h0, 0, 0, 0, 1, 0);
        step();
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0, 0);
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_sticky();
        test_mid_reset();
`ifdef ALU_EVENT_CNT_EN
        test_counters();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Registered output stage directly downstream of the 32-bit ALU. It captures each ALU result with its zero, overflow and exception flags into a small show-ahead FIFO with valid/ready handshakes on both sides. It also keeps sticky overflow and exception status bits for the control path. The register-write and branch-resolve logic consume its output.

## Interface
- `DATA_WIDTH`, 32, width of the result word
- `DEPTH`, 4, number of FIFO entries; power of two, at least 2
- `CNT_WIDTH`, 16, width of each event counter (used only with `ALU_EVENT_CNT_EN`)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  ALU result valid
- `in_ready`  out  1  queue can accept an entry
- `in_result`  in  DATA_WIDTH  ALU result word
- `in_zero`, `in_overflow`, `in_exception`  in  1 each  ALU flags
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  consumer accepts the head entry
- `out_result`  out  DATA_WIDTH  head result word
- `out_zero`, `out_overflow`, `out_exception`  out  1 each  head flags
- `level`  out  $clog2(DEPTH)+1  current occupancy
- `sticky_ovf`, `sticky_exc`  out  1 each  sticky status bits
- `sticky_clr`  in  1  clears both sticky bits
- `ovf_cnt`, `exc_cnt`  out  CNT_WIDTH each  event counters (only with `ALU_EVENT_CNT_EN`)

## Operation
- Push: occurs when `in_valid && in_ready`. `in_ready = (level != DEPTH)` and comes straight from registered state, with no combinational path from `out_ready`.
- Pop: occurs when `out_valid && out_ready`. `out_valid = (level != 0)`.
- Show-ahead: the `out_*` fields present the head entry. When `out_valid = 0`, `out_result`, `out_zero`, `out_overflow` and `out_exception` are forced to 0.
- Pointers: write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `level` is tracked separately.
- Simultaneous push and pop (possible only when 0 < level < DEPTH): both take effect and `level` is unchanged.
  - A push while empty is not visible at the head in the same cycle; there is no bypass.
- Full: `in_valid` is ignored and no entry is overwritten.
- Empty: `out_ready` is ignored and pointers do not move.
- Sticky bits:
  - `sticky_ovf` is set on an accepted push with `in_overflow = 1`.
  - `sticky_exc` is set on an accepted push with `in_exception = 1`.
  - `sticky_clr` clears both bits. If set and clear occur in the same cycle, set wins.
- Flags are stored exactly as received. The queue never recomputes `zero` from the result word.

## Timing
- Reset: `in_ready = 1`, `out_valid = 0`, `level = 0`, all `out_*` data fields 0, pointers 0, sticky bits 0, counters 0. Storage array contents are not reset.
- Reset mid-operation discards all entries on that edge. The first push after `rst` deasserts is accepted.
- Latency: a push at edge N gives `out_valid = 1` with that entry at the head during cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- `level` and the sticky bits update on the same edge as the push or pop that causes them.

## Configuration
- Macro: `ALU_EVENT_CNT_EN`.
- Defined:
  - `ovf_cnt` increments on each accepted push with `in_overflow = 1`.
  - `exc_cnt` increments on each accepted push with `in_exception = 1`.
  - Both counters saturate at all-ones, reset to 0, and are also cleared by `sticky_clr`. If clear and increment occur in the same cycle, the counter goes to 1.
- Undefined: the `ovf_cnt` and `exc_cnt` ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg` holds:
  - ALU function codes: ADD=2, SUB=6, AND=0, OR=1, SLL=8, SRL=9.
  - `DATA_WIDTH` default.
  - `typedef struct packed { logic [DATA_WIDTH-1:0] result; logic zero, overflow, exception; } alu_result_t`. FIFO storage is an array of this type.
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `rst`, `clr`, `inc`, `cnt`) is instantiated twice, only under `ALU_EVENT_CNT_EN`.

## Test plan
- Reset, then idle: `in_ready=1`, `out_valid=0`, `level=0`, `out_result=0`.
- Push 0x0000_0005, 0xFFFF_FFFF, 0x0, 0x8000_0000 with `out_ready=0`: `level` goes 1..4, then `in_ready=0`. A fifth push of 0x1234 is ignored. Four pops return the four values in order, the third with `out_zero=1`.
- Continuous push and pop every cycle with `level=2`: `level` holds at 2 and the output order matches the input order across pointer wrap (more than 8 entries).
- Push with `in_overflow=1` while `sticky_clr=1` in the same cycle: `sticky_ovf=1` next cycle. `sticky_clr` alone then gives `sticky_ovf=0`.
- Assert `rst` with `level=3`: next cycle `level=0` and `out_valid=0`. A push in the following cycle appears at the head one cycle later.
- With `ALU_EVENT_CNT_EN` and `CNT_WIDTH=2`: 5 pushes with `in_exception=1` give `exc_cnt=3` (saturated), and `sticky_clr` then gives `exc_cnt=0`.
